// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction SRAM-like request/response bus between fetch and memory
interface if_fetch_if;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;

  modport master (
    output inst_req_o,
    output inst_addr_o,
    input  inst_addr_ok_i,
    input  inst_data_ok_i,
    input  inst_rdata_i
  );

  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    output inst_addr_ok_i,
    output inst_data_ok_i,
    output inst_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with single outstanding request, stall buffer and redirects
module if_fetch (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  if_fetch_if.master  bus,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic [31:0] instr_o,
  output logic [7:0]  except_o,
  output logic        is_in_delayslot_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_CANCEL} state_t;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_target;
  logic        r_ds_pending;
  logic        r_redirect_pending;

  logic        w_misaligned;
  logic        w_req;
  logic        w_addr_hs;
  logic        w_fetch_valid;
  logic        w_deliver;
  logic        w_consume;
  logic [31:0] w_pcplus4;
  logic [31:0] w_next_pc;

  // A misaligned PC never reaches memory; it is delivered at once as an address-error bubble.
  assign w_misaligned  = (r_pc[1:0] != 2'b00);
  // Gating with rst_i keeps the request low while reset is held, so memory never sees a stale fetch.
  assign w_req         = (r_state == S_REQ) & ~w_misaligned & rst_i;
  assign w_addr_hs     = w_req & bus.inst_addr_ok_i;
  assign w_fetch_valid = ((r_state == S_WAIT) & bus.inst_data_ok_i)
                       | (r_state == S_HOLD)
                       | ((r_state == S_REQ) & w_misaligned);
  assign w_deliver     = w_fetch_valid & ~flush_i & rst_i;
  assign w_consume     = w_deliver & ~stall_i;
  assign w_pcplus4     = r_pc + 32'd4;
  // A branch resolving this cycle wins over an older stored redirect.
  assign w_next_pc     = branch_i           ? branch_target_i :
                         r_redirect_pending ? r_target        : w_pcplus4;

  assign bus.inst_req_o  = w_req;
  assign bus.inst_addr_o = r_pc;

  assign pc_o              = w_deliver ? r_pc : 32'd0;
  assign pcplus4_o         = w_deliver ? w_pcplus4 : 32'd0;
  assign instr_o           = !w_deliver                ? 32'd0 :
                             (r_state == S_HOLD)       ? r_buf :
                             w_misaligned              ? 32'd0 : bus.inst_rdata_i;
  assign except_o          = (w_deliver & w_misaligned) ? 8'h80 : 8'h00;
  // Whatever sits in fetch when ID resolves a branch is that branch's delay slot.
  assign is_in_delayslot_o = w_deliver & (r_ds_pending | branch_i);
  assign stall_req_o       = ~w_fetch_valid;

  // Fetch FSM: request, wait for data, hold under stall, cancel a request killed by flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state            <= S_REQ;
      r_pc               <= RESET_PC;
      r_buf              <= 32'd0;
      r_target           <= 32'd0;
      r_ds_pending       <= 1'b0;
      r_redirect_pending <= 1'b0;
    end else if (flush_i) begin
      r_pc               <= flush_pc_i;
      r_ds_pending       <= 1'b0;
      r_redirect_pending <= 1'b0;
      case (r_state)
        // An accepted or in-flight request still owes us a data beat that must be dropped.
        S_REQ:    r_state <= w_addr_hs ? S_CANCEL : S_REQ;
        S_WAIT:   r_state <= bus.inst_data_ok_i ? S_REQ : S_CANCEL;
        S_HOLD:   r_state <= S_REQ;
        S_CANCEL: r_state <= bus.inst_data_ok_i ? S_REQ : S_CANCEL;
        default:  r_state <= S_REQ;
      endcase
    end else if (w_consume) begin
      r_pc               <= w_next_pc;
      r_ds_pending       <= 1'b0;
      r_redirect_pending <= 1'b0;
      r_state            <= S_REQ;
    end else begin
      if (branch_i) begin
        r_ds_pending       <= 1'b1;
        r_redirect_pending <= 1'b1;
        r_target           <= branch_target_i;
      end
      case (r_state)
        S_REQ: begin
          if (w_addr_hs) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Data arriving while stalled is parked so the bus is free for nothing else to clobber it.
          if (bus.inst_data_ok_i) begin
            r_buf   <= bus.inst_rdata_i;
            r_state <= S_HOLD;
          end
        end
        S_HOLD:   r_state <= S_HOLD;
        S_CANCEL: begin
          if (bus.inst_data_ok_i) r_state <= S_REQ;
        end
        default:  r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed scoreboard bench for if_fetch
module tb_if_fetch;

  logic        clk;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic [31:0] pcplus4_o;
  logic [31:0] instr_o;
  logic [7:0]  except_o;
  logic        is_in_delayslot_o;
  logic        stall_req_o;

  if_fetch_if bus ();

  if_fetch dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .flush_pc_i       (flush_pc_i),
    .branch_i         (branch_i),
    .branch_target_i  (branch_target_i),
    .bus              (bus),
    .pc_o             (pc_o),
    .pcplus4_o        (pcplus4_o),
    .instr_o          (instr_o),
    .except_o         (except_o),
    .is_in_delayslot_o(is_in_delayslot_o),
    .stall_req_o      (stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  exc;
    logic        ds;
  } deliv_t;

  deliv_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                      input logic [7:0] exc, input logic ds);
    deliv_t e;
    e.pc = pc; e.instr = instr; e.exc = exc; e.ds = ds;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expected delivery and compare it with what the DUT presents now.
  task automatic pop_check(input string tag);
    deliv_t e;
    chk({tag, "_stall_req"}, {31'd0, stall_req_o}, 32'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pc"},      pc_o,                        e.pc);
      chk({tag, "_pcplus4"}, pcplus4_o,                   e.pc + 32'd4);
      chk({tag, "_instr"},   instr_o,                     e.instr);
      chk({tag, "_except"},  {24'd0, except_o},           {24'd0, e.exc});
      chk({tag, "_ds"},      {31'd0, is_in_delayslot_o},  {31'd0, e.ds});
    end
  endtask

  task automatic bus_idle();
    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b0;
    bus.inst_rdata_i   = 32'd0;
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'd0;
    branch_i = 1'b0; branch_target_i = 32'd0;
    bus_idle();
    step(); step();

    // Reset state
    settle();
    chk("rst_req",   {31'd0, bus.inst_req_o}, 32'd0);
    chk("rst_pc",    pc_o, 32'd0);
    chk("rst_instr", instr_o, 32'd0);

    // First fetch after reset release
    step();
    rst_i = 1'b1;
    bus.inst_addr_ok_i = 1'b1;
    settle();
    chk("first_req",  {31'd0, bus.inst_req_o}, 32'd1);
    chk("first_addr", bus.inst_addr_o, 32'hBFC0_0000);
    chk("wait_stall_req_pre", {31'd0, stall_req_o}, 32'd0 + 32'd1);
    step();
    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = 32'h2408_0001;
    push(32'hBFC0_0000, 32'h2408_0001, 8'h00, 1'b0);
    settle();
    pop_check("first");
    step();
    bus_idle();
    settle();
    chk("second_addr", bus.inst_addr_o, 32'hBFC0_0004);
    chk("second_req",  {31'd0, bus.inst_req_o}, 32'd1);

    // Stall for three cycles with data returned in the first
    bus.inst_addr_ok_i = 1'b1;
    step();
    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = 32'hAAAA_0004;
    stall_i = 1'b1;
    settle();
    chk("stall0_instr", instr_o, 32'hAAAA_0004);
    for (int i = 1; i < 3; i++) begin
      step();
      bus.inst_data_ok_i = 1'b0;
      bus.inst_rdata_i   = 32'hDEAD_BEEF;
      settle();
      chk($sformatf("hold%0d_instr", i), instr_o, 32'hAAAA_0004);
      chk($sformatf("hold%0d_req", i), {31'd0, bus.inst_req_o}, 32'd0);
      chk($sformatf("hold%0d_stall_req", i), {31'd0, stall_req_o}, 32'd0);
    end
    step();
    stall_i = 1'b0;
    push(32'hBFC0_0004, 32'hAAAA_0004, 8'h00, 1'b0);
    settle();
    pop_check("hold_release");
    step();
    bus_idle();
    settle();
    chk("after_hold_addr", bus.inst_addr_o, 32'hBFC0_0008);

    // Branch pulse while waiting: delay slot marked, redirect deferred
    bus.inst_addr_ok_i = 1'b1;
    step();
    bus.inst_addr_ok_i = 1'b0;
    branch_i = 1'b1;
    branch_target_i = 32'hBFC0_0100;
    settle();
    chk("br_wait_stall_req", {31'd0, stall_req_o}, 32'd1);
    step();
    branch_i = 1'b0;
    branch_target_i = 32'h0;
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = 32'h1111_0008;
    push(32'hBFC0_0008, 32'h1111_0008, 8'h00, 1'b1);
    settle();
    pop_check("ds_deferred");
    step();
    bus_idle();
    settle();
    chk("br_target_addr", bus.inst_addr_o, 32'hBFC0_0100);

    // Branch in the same cycle as consumption
    bus.inst_addr_ok_i = 1'b1;
    step();
    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = 32'h2222_0100;
    branch_i = 1'b1;
    branch_target_i = 32'hBFC0_0200;
    push(32'hBFC0_0100, 32'h2222_0100, 8'h00, 1'b1);
    settle();
    pop_check("ds_same");
    step();
    bus_idle();
    branch_i = 1'b0;
    settle();
    chk("br_same_addr", bus.inst_addr_o, 32'hBFC0_0200);

    // Flush in WAIT: late data discarded through CANCEL
    bus.inst_addr_ok_i = 1'b1;
    step();
    bus.inst_addr_ok_i = 1'b0;
    flush_i = 1'b1;
    flush_pc_i = 32'hBFC0_0380;
    settle();
    chk("flush_pc_zero", pc_o, 32'd0);
    step();
    flush_i = 1'b0;
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = 32'hBAD0_BAD0;
    settle();
    chk("cancel_stall_req", {31'd0, stall_req_o}, 32'd1);
    chk("cancel_req",       {31'd0, bus.inst_req_o}, 32'd0);
    chk("cancel_instr",     instr_o, 32'd0);
    step();
    bus_idle();
    settle();
    chk("flush_addr", bus.inst_addr_o, 32'hBFC0_0380);
    chk("flush_req",  {31'd0, bus.inst_req_o}, 32'd1);
    bus.inst_addr_ok_i = 1'b1;
    step();
    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = 32'h3333_0380;
    push(32'hBFC0_0380, 32'h3333_0380, 8'h00, 1'b0);
    settle();
    pop_check("post_flush");
    step();
    bus_idle();

    // Misaligned flush target: address-error bubble, no request
    flush_i = 1'b1;
    flush_pc_i = 32'hBFC0_0382;
    settle();
    step();
    flush_i = 1'b0;
    push(32'hBFC0_0382, 32'd0, 8'h80, 1'b0);
    settle();
    chk("mis_req", {31'd0, bus.inst_req_o}, 32'd0);
    pop_check("misaligned");
    step();
    flush_i = 1'b1;
    flush_pc_i = 32'hBFC0_0400;
    settle();
    chk("mis_flush_pc_zero",  pc_o, 32'd0);
    chk("mis_flush_exc_zero", {24'd0, except_o}, 32'd0);
    step();
    flush_i = 1'b0;
    settle();
    chk("realign_addr", bus.inst_addr_o, 32'hBFC0_0400);

    // Reset during WAIT
    bus.inst_addr_ok_i = 1'b1;
    step();
    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b1;
    bus.inst_rdata_i   = 32'h4444_0400;
    rst_i = 1'b0;
    settle();
    chk("arst_pc",    pc_o, 32'd0);
    chk("arst_instr", instr_o, 32'd0);
    chk("arst_req",   {31'd0, bus.inst_req_o}, 32'd0);
    step();
    bus_idle();
    rst_i = 1'b1;
    settle();
    chk("restart_req",  {31'd0, bus.inst_req_o}, 32'd1);
    chk("restart_addr", bus.inst_addr_o, 32'hBFC0_0000);

    chk("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  downstream if2id stall; delivered instruction not consumed.
- flush_i  in  1  exception/eret flush.
- flush_pc_i  in  32  flush target PC.
- branch_i  in  1  one-cycle pulse: instruction in ID is a taken branch/jump.
- branch_target_i  in  32  redirect target.
- inst_req_o  out  1  instruction SRAM-like request.
- inst_addr_o  out  32  request address.
- inst_addr_ok_i  in  1  request accepted.
- inst_data_ok_i  in  1  read data valid.
- inst_rdata_i  in  32  read data.
- pc_o, pcplus4_o, instr_o  out  32 each  to if2id.
- except_o  out  8  to if2id; bit 7 = fetch address error, others 0.
- is_in_delayslot_o  out  1  to if2id.
- stall_req_o  out  1  fetch not ready; to hazard unit.

Function
REQ-002 States SHALL be REQ, WAIT, HOLD, CANCEL; one outstanding request maximum.
REQ-003 REQ: inst_req_o=1, inst_addr_o=pc; on inst_addr_ok_i -> WAIT; address may change while unaccepted.
REQ-004 REQ with pc[1:0]!=0: inst_req_o=0; instruction delivered immediately with instr_o=0, except_o=8'h80.
REQ-005 fetch_valid SHALL be (WAIT & inst_data_ok_i) | HOLD | misaligned-REQ; stall_req_o = !fetch_valid.
REQ-006 When fetch_valid: instr_o = HOLD ? buffer : inst_rdata_i (same-cycle forward), pc_o=pc, pcplus4_o=pc+4 (mod 2^32); otherwise pc_o, pcplus4_o, instr_o, except_o = 0 and is_in_delayslot_o=0.
REQ-007 fetch_valid & !stall_i SHALL consume: pc <= next_pc, state -> REQ.
REQ-008 WAIT & inst_data_ok_i & stall_i SHALL capture inst_rdata_i into buffer, -> HOLD; HOLD persists until !stall_i.
REQ-009 next_pc SHALL be the redirect target if a redirect is pending or applies this cycle, else pc+4.
REQ-010 branch_i while an instruction is consumed that cycle: that instruction SHALL be marked is_in_delayslot_o=1 and next_pc=branch_target_i.
REQ-011 branch_i otherwise: ds_pending and redirect_pending SHALL set with target stored; next consumed instruction carries is_in_delayslot_o=1, next_pc=stored target, both flags clear.
REQ-012 flush_i SHALL take priority over branch_i and consumption: pc <= flush_pc_i, pending flags clear, outputs zero that cycle.
REQ-013 flush_i in WAIT without inst_data_ok_i, or in REQ with inst_addr_ok_i, SHALL go CANCEL; flush in REQ (no addr_ok), HOLD, or WAIT with data_ok SHALL go REQ.
REQ-014 CANCEL: inst_req_o=0, stall_req_o=1; on inst_data_ok_i data discarded, -> REQ; further flush_i updates pc only.

Reset
REQ-015 rst_i low SHALL immediately force state REQ, pc=32'hBFC0_0000, buffer=0, ds_pending=0, redirect_pending=0; all registered outputs zero.
REQ-016 First request SHALL issue in the first cycle after rst_i deasserts; reset mid-request abandons it (memory side reset together).

Verification
REQ-017 Reset release, addr_ok and data_ok one cycle later, instr 0x24080001 -> inst_addr_o=0xBFC00000, then pc_o=0xBFC00000, pcplus4_o=0xBFC00004, instr_o=0x24080001, next request 0xBFC00004.
REQ-018 data_ok with stall_i=1 for 3 cycles -> instr_o held from buffer, no new inst_req_o, stall_req_o=0; consumed on cycle stall_i falls.
REQ-019 branch_i at pc=0xBFC00008 WAIT, target 0xBFC00100 -> 0xBFC00008 delivered with is_in_delayslot_o=1, next inst_addr_o=0xBFC00100.
REQ-020 flush_i (flush_pc_i=0xBFC00380) in WAIT, data_ok next cycle -> returned data discarded, stall_req_o=1 during CANCEL, next request 0xBFC00380.
REQ-021 flush_pc_i=0xBFC00382 -> no inst_req_o, instr_o=0, except_o=8'h80, pc_o=0xBFC00382.
REQ-022 rst_i low during WAIT -> outputs zero asynchronously, restart from 0xBFC00000.
